m68k_bus_master: RTL and testbench

// Single-clock 68000 bus initiator for the accelerator board. It converts a simple request/ack port into

---
 rtl/m68k_bus_master.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_m68k_bus_master.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: turns a level request/ack port into arbitrated asynchronous 68000 bus cycles.
// Takes the bus via BR/BG/BGACK, runs AS/UDS/LDS/RW strobes and terminates on DTACK, BERR or timeout.
module m68k_bus_master #(
   parameter int ADDR_SETUP  = 2,
   parameter int WDATA_SETUP = 2,
   parameter int HOLD        = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic        CLKOSC,
   input  logic        RST,
   input  logic        REQ,
   input  logic        REQ_RW,
   input  logic [22:0] REQ_A,
   input  logic        REQ_UDS,
   input  logic        REQ_LDS,
   input  logic [15:0] REQ_WDATA,
   output logic        ACK,
   output logic        ERR,
   output logic [15:0] RDATA,
   output logic        BR,
   input  logic        BG,
   output logic        BGACK,
   input  logic        AS_IN,
   input  logic        DTACK,
   input  logic        BERR,
   output logic        AS_OUT,
   output logic        UDS_OUT,
   output logic        LDS_OUT,
   output logic        RW_OUT,
   output logic [22:0] A_OUT,
   output logic [15:0] D_OUT,
   input  logic [15:0] D_IN,
   output logic        A_OE,
   output logic        D_OE
);

   localparam int CNT_W = 10;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ARB,
      ST_TAKE,
      ST_OWN,
      ST_ADDR,
      ST_STRB,
      ST_WAIT,
      ST_TERM,
      ST_HOLD
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;

   logic [1:0] bg_sync;
   logic [1:0] as_sync;
   logic [1:0] dtack_sync;
   logic [1:0] berr_sync;
   logic       bg_s;
   logic       as_s;
   logic       dtack_s;
   logic       berr_s;

   logic        rd;
   logic        rd_nx;
   logic        uds_q;
   logic        uds_q_nx;
   logic        lds_q;
   logic        lds_q_nx;
   logic        br_nx;
   logic        bgack_nx;
   logic        as_nx;
   logic        uds_nx;
   logic        lds_nx;
   logic        rw_nx;
   logic        a_oe_nx;
   logic        d_oe_nx;
   logic        ack_nx;
   logic        err_nx;
   logic [15:0] rdata_nx;
   logic [22:0] a_nx;
   logic [15:0] d_nx;

   logic illegal;
   logic accept;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // True on the last cycle of an n-cycle interval whose counter started at 0.
   function automatic logic reached(input logic [CNT_W-1:0] v, input int n);
      return (int'(v) + 1) >= n;
   endfunction

   // Two-flop synchronisers for every asynchronous bus input.
   always_ff @(posedge CLKOSC) begin
      if (!RST) begin
         bg_sync    <= 2'b11;
         as_sync    <= 2'b11;
         dtack_sync <= 2'b11;
         berr_sync  <= 2'b11;
      end else begin
         bg_sync    <= {bg_sync[0], BG};
         as_sync    <= {as_sync[0], AS_IN};
         dtack_sync <= {dtack_sync[0], DTACK};
         berr_sync  <= {berr_sync[0], BERR};
      end
   end

   assign bg_s    = bg_sync[1];
   assign as_s    = as_sync[1];
   assign dtack_s = dtack_sync[1];
   assign berr_s  = berr_sync[1];

   assign illegal = REQ_UDS & REQ_LDS;
   // The ACK term keeps a still-high REQ from being taken twice in consecutive cycles.
   assign accept  = REQ & ~ACK;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rd_nx    = rd;
      uds_q_nx = uds_q;
      lds_q_nx = lds_q;
      br_nx    = BR;
      bgack_nx = BGACK;
      as_nx    = AS_OUT;
      uds_nx   = UDS_OUT;
      lds_nx   = LDS_OUT;
      rw_nx    = RW_OUT;
      a_oe_nx  = A_OE;
      d_oe_nx  = D_OE;
      ack_nx   = 1'b0;
      err_nx   = 1'b0;
      rdata_nx = RDATA;
      a_nx     = A_OUT;
      d_nx     = D_OUT;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (illegal) begin
                  ack_nx = 1'b1;
                  err_nx = 1'b1;
               end else begin
                  br_nx    = 1'b0;
                  state_nx = ST_ARB;
               end
            end
         end

         ST_ARB: begin
            if (!bg_s && as_s && dtack_s) begin
               bgack_nx = 1'b0;
               a_oe_nx  = 1'b1;
               br_nx    = 1'b1;
               state_nx = ST_TAKE;
            end
         end

         ST_TAKE: begin
            state_nx = ST_OWN;
         end

         ST_OWN: begin
            if (accept) begin
               if (illegal) begin
                  ack_nx = 1'b1;
                  err_nx = 1'b1;
               end else begin
                  rd_nx    = REQ_RW;
                  uds_q_nx = REQ_UDS;
                  lds_q_nx = REQ_LDS;
                  a_nx     = REQ_A;
                  rw_nx    = REQ_RW;
                  cnt_nx   = '0;
                  if (!REQ_RW) begin
                     d_oe_nx = 1'b1;
                     d_nx    = REQ_WDATA;
                  end
                  state_nx = ST_ADDR;
               end
            end else if (!REQ) begin
               bgack_nx = 1'b1;
               a_oe_nx  = 1'b0;
               state_nx = ST_IDLE;
            end
         end

         ST_ADDR: begin
            // The previous responder must have let DTACK/BERR go before a new AS.
            if (reached(cnt, ADDR_SETUP) && dtack_s && berr_s) begin
               as_nx  = 1'b0;
               cnt_nx = '0;
               if (rd) begin
                  uds_nx   = uds_q;
                  lds_nx   = lds_q;
                  state_nx = ST_WAIT;
               end else begin
                  state_nx = ST_STRB;
               end
            end else begin
               cnt_nx = sat_inc(cnt);
            end
         end

         ST_STRB: begin
            if (reached(cnt, WDATA_SETUP)) begin
               uds_nx   = uds_q;
               lds_nx   = lds_q;
               cnt_nx   = '0;
               state_nx = ST_WAIT;
            end else begin
               cnt_nx = sat_inc(cnt);
            end
         end

         ST_WAIT: begin
            if (!berr_s || !dtack_s || cnt == CNT_W'(TIMEOUT)) begin
               as_nx    = 1'b1;
               uds_nx   = 1'b1;
               lds_nx   = 1'b1;
               ack_nx   = 1'b1;
               err_nx   = !berr_s || dtack_s;
               cnt_nx   = '0;
               state_nx = ST_TERM;
               // D_IN was driven before DTACK, so the synchroniser delay gives it time to settle.
               if (berr_s && !dtack_s && rd) begin
                  rdata_nx = D_IN;
               end
            end else begin
               cnt_nx = sat_inc(cnt);
            end
         end

         ST_TERM: begin
            cnt_nx   = '0;
            state_nx = ST_HOLD;
         end

         ST_HOLD: begin
            if (reached(cnt, HOLD)) begin
               d_oe_nx  = 1'b0;
               rw_nx    = 1'b1;
               cnt_nx   = '0;
               state_nx = ST_OWN;
            end else begin
               cnt_nx = sat_inc(cnt);
            end
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLKOSC) begin
      if (!RST) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         rd      <= 1'b1;
         uds_q   <= 1'b1;
         lds_q   <= 1'b1;
         BR      <= 1'b1;
         BGACK   <= 1'b1;
         AS_OUT  <= 1'b1;
         UDS_OUT <= 1'b1;
         LDS_OUT <= 1'b1;
         RW_OUT  <= 1'b1;
         A_OE    <= 1'b0;
         D_OE    <= 1'b0;
         ACK     <= 1'b0;
         ERR     <= 1'b0;
         RDATA   <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         rd      <= rd_nx;
         uds_q   <= uds_q_nx;
         lds_q   <= lds_q_nx;
         BR      <= br_nx;
         BGACK   <= bgack_nx;
         AS_OUT  <= as_nx;
         UDS_OUT <= uds_nx;
         LDS_OUT <= lds_nx;
         RW_OUT  <= rw_nx;
         A_OE    <= a_oe_nx;
         D_OE    <= d_oe_nx;
         ACK     <= ack_nx;
         ERR     <= err_nx;
         RDATA   <= rdata_nx;
      end
   end

   // Address and write data are only meaningful while their enables are set.
   always_ff @(posedge CLKOSC) begin
      A_OUT <= a_nx;
      D_OUT <= d_nx;
   end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: CPU arbiter and DTACK responder models around the DUT,
// with a word-memory reference model feeding a scoreboard that a separate monitor drains.
module tb_m68k_bus_master;

   localparam int ADDR_SETUP  = 2;
   localparam int WDATA_SETUP = 2;
   localparam int HOLD        = 2;
   localparam int TIMEOUT     = 1023;

   localparam int M_OK   = 0;
   localparam int M_BERR = 1;
   localparam int M_TMO  = 2;
   localparam int M_ILL  = 3;

   logic        CLKOSC;
   logic        RST;
   logic        REQ;
   logic        REQ_RW;
   logic [22:0] REQ_A;
   logic        REQ_UDS;
   logic        REQ_LDS;
   logic [15:0] REQ_WDATA;
   logic        ACK;
   logic        ERR;
   logic [15:0] RDATA;
   logic        BR;
   logic        BG;
   logic        BGACK;
   logic        AS_IN;
   logic        DTACK;
   logic        BERR;
   logic        AS_OUT;
   logic        UDS_OUT;
   logic        LDS_OUT;
   logic        RW_OUT;
   logic [22:0] A_OUT;
   logic [15:0] D_OUT;
   logic [15:0] D_IN;
   logic        A_OE;
   logic        D_OE;

   m68k_bus_master #(
      .ADDR_SETUP(ADDR_SETUP), .WDATA_SETUP(WDATA_SETUP), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLKOSC(CLKOSC), .RST(RST), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_A(REQ_A),
      .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS), .REQ_WDATA(REQ_WDATA),
      .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .BR(BR), .BG(BG), .BGACK(BGACK),
      .AS_IN(AS_IN), .DTACK(DTACK), .BERR(BERR), .AS_OUT(AS_OUT), .UDS_OUT(UDS_OUT),
      .LDS_OUT(LDS_OUT), .RW_OUT(RW_OUT), .A_OUT(A_OUT), .D_OUT(D_OUT), .D_IN(D_IN),
      .A_OE(A_OE), .D_OE(D_OE)
   );

   typedef struct {
      bit          rw;
      logic [22:0] a;
      bit          uds;
      bit          lds;
      int          mode;
      bit          err;
      logic [15:0] rdata;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] shadow    [logic [22:0]];
   logic [15:0] slave_mem [logic [22:0]];
   logic [15:0] last_rd;
   int          n_vec;
   int          n_bad;
   int          s_mode;
   int          s_dly;
   int          gnt_dly;
   int          br_falls;

   initial begin
      CLKOSC = 1'b0;
      forever #5 CLKOSC = ~CLKOSC;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] init_w(input logic [22:0] a);
      return a[15:0] ^ 16'hA5C3;
   endfunction

   function automatic logic [15:0] shadow_rd(input logic [22:0] a);
      return shadow.exists(a) ? shadow[a] : init_w(a);
   endfunction

   function automatic logic [15:0] slave_rd(input logic [22:0] a);
      return slave_mem.exists(a) ? slave_mem[a] : init_w(a);
   endfunction

   // Reference model: a word memory with active-low byte selects; errors leave memory and RDATA alone.
   task automatic txn(input bit rw, input logic [22:0] a, input bit u, input bit l,
                      input logic [15:0] wd, input int mode, input int dly, output int lat);
      exp_t        e;
      logic [15:0] cur;
      bit          got;
      e.rw   = rw;
      e.a    = a;
      e.uds  = u;
      e.lds  = l;
      e.mode = mode;
      e.err  = (mode != M_OK);
      if (mode == M_OK && rw) last_rd = shadow_rd(a);
      if (mode == M_OK && !rw) begin
         cur = shadow_rd(a);
         shadow[a] = {u ? cur[15:8] : wd[15:8], l ? cur[7:0] : wd[7:0]};
      end
      e.rdata = last_rd;
      sbq.push_back(e);
      s_mode    = mode;
      s_dly     = dly;
      REQ_RW    = rw;
      REQ_A     = a;
      REQ_UDS   = u;
      REQ_LDS   = l;
      REQ_WDATA = wd;
      REQ       = 1'b1;
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge CLKOSC);
         lat++;
         got = ACK;
      end
      if (!got) check("ack_timeout", 32'd0, 32'd1);
      REQ = 1'b0;
   endtask

   // CPU side of arbitration: grant after gnt_dly cycles of BR, withdraw BG once BGACK is seen.
   initial begin
      int wcnt;
      int gcnt;
      bit pend;
      bit prev_br;
      BG = 1'b1;
      wcnt = 0;
      gcnt = 0;
      pend = 1'b0;
      prev_br = 1'b1;
      br_falls = 0;
      forever begin
         @(negedge CLKOSC);
         if (prev_br && !BR) br_falls++;
         prev_br = BR;
         if (pend) begin
            gcnt++;
            if (!BGACK) begin
               check("bgack_latency", gcnt, 3);
               pend = 1'b0;
               BG = 1'b1;
            end else if (gcnt > 20) begin
               check("bgack_never", 32'd0, 32'd1);
               pend = 1'b0;
               BG = 1'b1;
            end
         end else if (!BR && BG) begin
            wcnt++;
            if (wcnt >= gnt_dly) begin
               BG = 1'b0;
               pend = 1'b1;
               gcnt = 0;
               wcnt = 0;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Responder: DTACK (or BERR with DTACK) s_dly cycles after data strobe, released when AS negates.
   initial begin
      bit          resp;
      int          dc;
      logic [15:0] wv;
      logic [15:0] cur;
      DTACK = 1'b1;
      BERR = 1'b1;
      D_IN = 16'h0;
      resp = 1'b0;
      dc = 0;
      forever begin
         @(negedge CLKOSC);
         if (AS_OUT) begin
            if (resp) D_IN = 16'($urandom);
            DTACK = 1'b1;
            BERR = 1'b1;
            resp = 1'b0;
            dc = 0;
         end else if (!resp && (!UDS_OUT || !LDS_OUT)) begin
            dc++;
            if (s_mode != M_TMO && dc >= s_dly) begin
               resp = 1'b1;
               if (s_mode == M_BERR) begin
                  D_IN = 16'($urandom);
                  BERR = 1'b0;
                  DTACK = 1'b0;
               end else begin
                  if (!RW_OUT) begin
                     wv = D_OE ? D_OUT : 16'hDEAD;
                     cur = slave_rd(A_OUT);
                     slave_mem[A_OUT] = {UDS_OUT ? cur[15:8] : wv[15:8], LDS_OUT ? cur[7:0] : wv[7:0]};
                  end else begin
                     D_IN = slave_rd(A_OUT);
                  end
                  DTACK = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every ACK and checks strobe timing observed during the cycle.
   initial begin
      exp_t        e;
      bit          as_seen;
      bit          ds_seen;
      int          as_cnt;
      int          as2ds;
      int          ds_cnt;
      bit          ds_u;
      bit          ds_l;
      int          hold_left;
      bit          hold_rw;
      logic [22:0] hold_a;
      as_seen = 1'b0;
      ds_seen = 1'b0;
      as_cnt = 0;
      as2ds = 0;
      ds_cnt = 0;
      ds_u = 1'b1;
      ds_l = 1'b1;
      hold_left = 0;
      hold_rw = 1'b1;
      hold_a = '0;
      forever begin
         @(negedge CLKOSC);
         if (!RST) begin
            as_seen = 1'b0;
            ds_seen = 1'b0;
            ds_cnt = 0;
            hold_left = 0;
            continue;
         end
         if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
               check("hold_d_oe", D_OE, !hold_rw);
               check("hold_addr", A_OUT, hold_a);
            end
         end
         if (!AS_OUT) begin
            if (!as_seen) as_cnt = 0;
            else as_cnt++;
            as_seen = 1'b1;
            if (!ds_seen && (!UDS_OUT || !LDS_OUT)) begin
               ds_seen = 1'b1;
               as2ds = as_cnt;
               ds_u = UDS_OUT;
               ds_l = LDS_OUT;
            end
         end
         if (!UDS_OUT || !LDS_OUT) ds_cnt++;
         if (ACK) begin
            if (sbq.size() == 0) begin
               check("unexpected_ack", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               check("err", ERR, e.err);
               if (e.mode == M_ILL) begin
                  check("illegal_no_as", as_seen, 1'b0);
               end else begin
                  check("ds_select", {ds_u, ds_l}, {e.uds, e.lds});
                  check("as_to_ds", as2ds, e.rw ? 0 : WDATA_SETUP);
                  hold_left = HOLD;
                  hold_rw = e.rw;
                  hold_a = e.a;
               end
               if (e.rw || e.err) check("rdata", RDATA, e.rdata);
               if (e.mode == M_TMO) check("timeout_cycles", ds_cnt, TIMEOUT + 1);
            end
            as_seen = 1'b0;
            ds_seen = 1'b0;
            ds_cnt = 0;
         end else if (ERR) begin
            check("err_without_ack", 32'd1, 32'd0);
         end
      end
   end

   initial begin
      int          lat;
      int          br0;
      int          r;
      int          mode;
      int          sel;
      int          gap;
      bit          rw;
      bit          u;
      bit          l;
      bit          got;
      logic [22:0] a;
      n_vec = 0;
      n_bad = 0;
      last_rd = 16'h0;
      s_mode = M_OK;
      s_dly = 1;
      gnt_dly = 3;
      RST = 1'b0;
      REQ = 1'b0;
      REQ_RW = 1'b1;
      REQ_A = '0;
      REQ_UDS = 1'b0;
      REQ_LDS = 1'b0;
      REQ_WDATA = '0;
      AS_IN = 1'b1;
      repeat (3) @(negedge CLKOSC);
      check("reset_ctrl", {BR, BGACK, AS_OUT, UDS_OUT, LDS_OUT, RW_OUT, A_OE, D_OE, ACK, ERR},
            10'b1111110000);
      check("reset_rdata", RDATA, 16'h0);
      RST = 1'b1;
      @(negedge CLKOSC);

      // Directed cases: read with known data, upper-byte write and readback, BERR+DTACK, timeout.
      slave_mem[23'h80] = 16'hBEEF;
      shadow[23'h80] = 16'hBEEF;
      txn(1'b1, 23'h80, 1'b0, 1'b0, 16'h0, M_OK, 5, lat);
      txn(1'b0, 23'h50000, 1'b0, 1'b1, 16'h1234, M_OK, 3, lat);
      txn(1'b1, 23'h50000, 1'b0, 1'b0, 16'h0, M_OK, 2, lat);
      txn(1'b1, 23'h80, 1'b0, 1'b0, 16'h0, M_BERR, 2, lat);
      repeat (10) @(negedge CLKOSC);
      gnt_dly = 2;
      txn(1'b1, 23'h123, 1'b0, 1'b0, 16'h0, M_TMO, 1, lat);
      repeat (10) @(negedge CLKOSC);
      check("release_after_timeout", {BGACK, A_OE, BR}, 3'b101);

      // Three back-to-back requests under one ownership.
      br0 = br_falls;
      txn(1'b0, 23'h401, 1'b0, 1'b0, 16'hA001, M_OK, 1, lat);
      txn(1'b1, 23'h401, 1'b1, 1'b0, 16'h0, M_OK, 2, lat);
      txn(1'b0, 23'h402, 1'b1, 1'b0, 16'h0B0B, M_OK, 4, lat);
      repeat (10) @(negedge CLKOSC);
      check("b2b_single_br", br_falls - br0, 1);
      check("b2b_released", BGACK, 1'b1);

      txn(1'b1, 23'h404, 1'b1, 1'b1, 16'h0, M_ILL, 1, lat);
      check("illegal_latency", lat, 1);
      check("illegal_no_br", br_falls - br0, 1);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 99);
         mode = (r < 10) ? M_ILL : (r < 22) ? M_BERR : M_OK;
         rw = 1'($urandom_range(0, 1));
         a = 23'h400 + 23'($urandom_range(0, 7));
         sel = $urandom_range(0, 2);
         u = (sel == 2);
         l = (sel == 1);
         if (mode == M_ILL) begin
            u = 1'b1;
            l = 1'b1;
         end
         gnt_dly = $urandom_range(1, 4);
         txn(rw, a, u, l, 16'($urandom), mode, $urandom_range(1, 6), lat);
         gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8);
         repeat (gap) @(negedge CLKOSC);
      end
      repeat (10) @(negedge CLKOSC);
      check("final_release", {BGACK, A_OE, BR}, 3'b101);
      check("scoreboard_drained", sbq.size(), 0);

      // Reset in the middle of a stuck read must drop the bus at the next edge without an ACK.
      s_mode = M_TMO;
      gnt_dly = 2;
      REQ_RW = 1'b1;
      REQ_A = 23'h7FC400;
      REQ_UDS = 1'b0;
      REQ_LDS = 1'b0;
      REQ = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge CLKOSC);
         got = !UDS_OUT && !LDS_OUT;
      end
      check("midwait_reached", got, 1'b1);
      repeat (3) @(negedge CLKOSC);
      RST = 1'b0;
      REQ = 1'b0;
      @(posedge CLKOSC);
      #1;
      check("rst_strobes", {AS_OUT, UDS_OUT, LDS_OUT}, 3'b111);
      check("rst_bus_release", {BGACK, A_OE}, 2'b10);
      check("rst_no_ack", ACK, 1'b0);
      @(negedge CLKOSC);
      RST = 1'b1;
      repeat (4) @(negedge CLKOSC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
